mux4_rr_arbiter: RTL
====================

Name: mux4_rr_arbiter

Overview:
- Round-robin arbiter sharing one 4:1 mux output channel between four requesters.
- Selects one requester, drives the mux select and one-hot grant, and streams that requester's data beats to a single consumer with a valid/ready handshake.
- Caps each grant at BURST beats so no requester can starve the others.
- Sits between four producer blocks and one downstream sink.

Parameters:
- DATA_W, 8, width of each requester's data word.
- BURST, 4, maximum beats per grant; legal range 1..15.

Ports:
- clk  input  1  system clock, rising-edge.
- rst  input  1  asynchronous, active-high reset.
- req  input  4  req[i] high while requester i has a beat to send; requester holds its data stable while req is high.
- din  input  4*DATA_W  flattened requester data; requester i occupies din[i*DATA_W +: DATA_W].
- out_ready  input  1  sink accepts a beat this cycle.
- out_valid  output  1  a beat is presented on out_data.
- out_data  output  DATA_W  data of the granted requester (4:1 mux output).
- sel  output  2  registered mux select (index of granted requester).
- gnt  output  4  registered one-hot grant; all zero when idle.
- ack  output  4  one-hot; ack[i] high for exactly the cycle in which requester i's beat is transferred.
- busy  output  1  high in state GRANT.

Behaviour:
- Reset (asynchronous, immediate): state=IDLE, ptr=0, sel=0, gnt=0, cnt=0. Outputs out_valid=0, ack=0, busy=0; out_data shows din slot 0.
- State register: IDLE, GRANT.
- Internal state: ptr[1:0] is the highest-priority index; cnt is a beat counter of width clog2(BURST)+1.
- IDLE:
  - gnt=0, out_valid=0, ack=0.
  - If req!=0: winner = first i with req[i]=1, searching ptr, ptr+1, ptr+2, ptr+3 (mod 4).
  - Next edge: sel<=winner, gnt<=1<<winner, cnt<=0, state<=GRANT.
  - If req==0: stay in IDLE.
- GRANT:
  - out_valid = req[sel] (combinational). out_data = din slot sel (combinational mux). ack = gnt when out_valid && out_ready, else 0.
  - On a transfer (out_valid && out_ready): cnt<=cnt+1.
  - Grant ends when either:
    - a transfer occurs with cnt==BURST-1, or
    - req[sel]==0 in that cycle (no transfer possible).
  - On grant end, next edge: state<=IDLE, gnt<=0, ptr<=sel+1 (mod 4, wraps 3->0). sel holds its value.
  - Otherwise stay in GRANT. out_ready low only stalls: no cnt change, grant held indefinitely.
- Latency:
  - req rising in IDLE to gnt and first possible out_valid: 1 cycle.
  - There is always exactly one IDLE cycle between consecutive grants, including back-to-back grants to the same requester.
- Fairness: after a grant to i, requester i has lowest priority. Four continuously requesting masters are served 0,1,2,3,0... from reset.
- Boundary cases:
  - req of a non-granted requester changing mid-grant: ignored until the next IDLE.
  - BURST=1: grant ends on the first transfer.
  - Simultaneous last transfer and req[sel] falling: at most one beat was transferred; grant ends.
  - Reset mid-grant: grant aborts immediately, ptr returns to 0, no ack is generated.
- ack, gnt and out_valid are never asserted for more than one requester at once.

Test Plan:
- Reset, then req=4'b0001, out_ready=1, din slot0 = 8'hA0..A3 per beat, held 6 beats -> gnt=0001 one cycle after req, sel=0. Exactly 4 acks (A0..A3 on out_data). One IDLE cycle with gnt=0. Regrant to 0 with 2 more beats.
- req=4'b1111 held, out_ready=1, BURST=4 -> grant order 0,1,2,3,0. Each grant has 4 ack pulses followed by one IDLE cycle. ptr wraps 3->0.
- Grant on requester 2, out_ready=0 for 5 cycles -> out_valid=1, ack=0, cnt frozen, gnt=0100 held. out_ready=1 then resumes the count.
- Requester 1 granted, drops req after 2 beats -> grant ends after 2 acks. Next IDLE with req=4'b0011 grants requester 0? No: ptr=2, so the search order is 2,3,0 -> requester 0 is granted (sel=0).
- Assert rst asynchronously mid-grant (requester 3, cnt=2) -> gnt, out_valid, ack and busy are 0 before the next clk edge. After release with req=4'b1000, requester 3 is regranted with cnt restarting at 0.
- Check across all tests -> onehot0(gnt) and onehot0(ack) always hold; ack is never high while out_ready=0.

Source files
------------

// File: rtl/mux4_rr_arbiter.sv
// Round-robin arbiter that shares a 4:1 mux output channel between four
// requesters, streaming up to BURST beats per grant over a valid/ready link.
module mux4_rr_arbiter #(
   parameter int DATA_W = 8,
   parameter int BURST  = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [3:0]            req,
   input  logic [4*DATA_W-1:0]   din,
   input  logic                  out_ready,
   output logic                  out_valid,
   output logic [DATA_W-1:0]     out_data,
   output logic [1:0]            sel,
   output logic [3:0]            gnt,
   output logic [3:0]            ack,
   output logic                  busy
);

   localparam int CNT_W = $clog2(BURST) + 1;

   localparam logic [0:0] IDLE  = 1'b0;
   localparam logic [0:0] GRANT = 1'b1;

   logic [0:0]       state;
   logic [1:0]       ptr;
   logic [1:0]       winner;
   logic [CNT_W-1:0] cnt;
   logic             xfer;
   logic             grant_end;

   // Scan from the farthest offset down so the nearest requester to ptr wins.
   always_comb begin
      winner = ptr;
      for (int k = 3; k >= 0; k--) begin
         if (req[ptr + 2'(k)]) winner = ptr + 2'(k);
      end
   end

   always_comb begin
      out_data = din[DATA_W-1:0];
      case (sel)
         2'd0: out_data = din[0*DATA_W +: DATA_W];
         2'd1: out_data = din[1*DATA_W +: DATA_W];
         2'd2: out_data = din[2*DATA_W +: DATA_W];
         2'd3: out_data = din[3*DATA_W +: DATA_W];
         default: out_data = din[DATA_W-1:0];
      endcase
   end

   // Handshake: a beat moves on any cycle where out_valid and out_ready are
   // both high at the rising edge; out_valid follows req[sel] while granted.
   assign busy      = (state == GRANT);
   assign out_valid = busy & req[sel];
   assign xfer      = out_valid & out_ready;
   assign ack       = xfer ? gnt : 4'b0000;
   assign grant_end = busy & (~req[sel] | (xfer & (cnt == CNT_W'(BURST - 1))));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
         ptr   <= 2'd0;
         sel   <= 2'd0;
         gnt   <= 4'b0000;
         cnt   <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (|req) begin
                  sel   <= winner;
                  gnt   <= 4'b0001 << winner;
                  cnt   <= '0;
                  state <= GRANT;
               end
            end
            GRANT: begin
               if (grant_end) begin
                  state <= IDLE;
                  gnt   <= 4'b0000;
                  ptr   <= sel + 2'd1;
               end else if (xfer) begin
                  cnt <= cnt + 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
